// File: rtl/cordic_seq_if.sv
// Handshake bundle between the CORDIC control wrapper (master) and the
// iteration sequencer (slave).
interface cordic_seq_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             hold;
    logic             abort;
    logic [CNT_W-1:0] iter_idx;
    logic             iter_valid;
    logic             first;
    logic             last;
    logic             comp_valid;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, hold, abort,
        input  iter_idx, iter_valid, first, last, comp_valid, busy, done, aborted
    );

    modport slave (
        input  start, hold, abort,
        output iter_idx, iter_valid, first, last, comp_valid, busy, done, aborted
    );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// Iteration sequencer for the iterative CORDIC datapath: walks iter_idx over
// ITER micro-rotations with stall/abort/restart. Define CORDIC_SEQ_COMP_EN to
// insert one gain-compensation cycle between the last iteration and DONE.
module cordic_iter_sequencer #(
    parameter int unsigned ITER  = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cordic_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER - 1);

`ifdef CORDIC_SEQ_COMP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_COMP = 2'd2, S_DONE = 2'd3} state_t;
    localparam state_t AFTER_RUN = S_COMP;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
    localparam state_t AFTER_RUN = S_DONE;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_idx;
    logic             r_aborted;
    logic             w_iter_valid;

    // Sequence state, index and abort acknowledge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_idx     <= '0;
                        r_aborted <= 1'b1;
                    end else if (!bus.hold) begin
                        if (r_idx == LAST_IDX) r_state <= AFTER_RUN;
                        else                   r_idx   <= r_idx + CNT_W'(1);
                    end
                end
`ifdef CORDIC_SEQ_COMP_EN
                S_COMP: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_idx     <= '0;
                        r_aborted <= 1'b1;
                    end else if (!bus.hold) begin
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    // Restart straight from DONE to avoid an IDLE bubble
                    r_state <= bus.start ? S_RUN : S_IDLE;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign w_iter_valid   = (r_state == S_RUN) & ~bus.hold & ~bus.abort;
    assign bus.iter_valid = w_iter_valid;
    assign bus.first      = w_iter_valid & (r_idx == '0);
    assign bus.last       = w_iter_valid & (r_idx == LAST_IDX);
`ifdef CORDIC_SEQ_COMP_EN
    assign bus.comp_valid = (r_state == S_COMP) & ~bus.hold;
    assign bus.busy       = (r_state == S_RUN) | (r_state == S_COMP);
`else
    assign bus.comp_valid = 1'b0;
    assign bus.busy       = (r_state == S_RUN);
`endif
    assign bus.iter_idx   = r_idx;
    assign bus.done       = (r_state == S_DONE);
    assign bus.aborted    = r_aborted;
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Bench for cordic_iter_sequencer: three instances (ITER 16/5/2) share one
// stimulus stream and are checked every cycle against a progress-count model.
module tb_cordic_iter_sequencer;
`ifdef CORDIC_SEQ_COMP_EN
    localparam int COMP = 1;
`else
    localparam int COMP = 0;
`endif
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n, start, hold, abort;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cordic_seq_if #(.CNT_W(4)) if16 ();
    cordic_seq_if #(.CNT_W(3)) if5  ();
    cordic_seq_if #(.CNT_W(1)) if2  ();

    cordic_iter_sequencer #(.ITER(16), .CNT_W(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    cordic_iter_sequencer #(.ITER(5),  .CNT_W(3)) u5  (.clk(clk), .rst_n(rst_n), .bus(if5));
    cordic_iter_sequencer #(.ITER(2),  .CNT_W(1)) u2  (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if16.start = start; assign if16.hold = hold; assign if16.abort = abort;
    assign if5.start  = start; assign if5.hold  = hold; assign if5.abort  = abort;
    assign if2.start  = start; assign if2.hold  = hold; assign if2.abort  = abort;

    // Observed outputs packed per instance: {valid,first,last,comp,busy,done,aborted}
    logic [3:0] o_idx [NI];
    logic [6:0] o_flg [NI];
    assign o_idx[0] = 4'(if16.iter_idx);
    assign o_idx[1] = 4'(if5.iter_idx);
    assign o_idx[2] = 4'(if2.iter_idx);
    assign o_flg[0] = {if16.iter_valid, if16.first, if16.last, if16.comp_valid, if16.busy, if16.done, if16.aborted};
    assign o_flg[1] = {if5.iter_valid,  if5.first,  if5.last,  if5.comp_valid,  if5.busy,  if5.done,  if5.aborted};
    assign o_flg[2] = {if2.iter_valid,  if2.first,  if2.last,  if2.comp_valid,  if2.busy,  if2.done,  if2.aborted};

    // Model: mode 0 idle, 1 operating, 2 done; pos = non-stalled cycles consumed
    int m_mode [NI];
    int m_pos  [NI];
    bit m_ack  [NI];
    bit m_idxk [NI];

    function automatic int n_of(input int i);
        return (i == 0) ? 16 : (i == 1) ? 5 : 2;
    endfunction

    task automatic check(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst_iter=%0d observed=%h expected=%h t=%0t", tag, n_of(i), obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_mode[i] = 0; m_pos[i] = 0; m_ack[i] = 1'b0; m_idxk[i] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int  n;
            bit  op, v, cv;
            n  = n_of(i);
            op = (m_mode[i] == 1);
            v  = op && (m_pos[i] < n) && !hold && !abort;
            cv = op && (m_pos[i] == n) && !hold;
            check("flags", i, 8'({v, v && m_pos[i] == 0, v && m_pos[i] == n - 1, cv,
                                   op, m_mode[i] == 2, m_ack[i]}), 8'(o_flg[i]));
            if (op || m_mode[i] == 2)
                check("iter_idx", i, 8'(o_idx[i]), 8'((m_pos[i] < n) ? m_pos[i] : n - 1));
            else if (m_idxk[i])
                check("iter_idx_zero", i, 8'(o_idx[i]), 8'd0);
        end
    endtask

    task automatic update_all();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            m_ack[i] = 1'b0;
            case (m_mode[i])
                0: if (start) begin m_mode[i] = 1; m_pos[i] = 0; end
                1: begin
                    if (abort) begin
                        m_mode[i] = 0; m_ack[i] = 1'b1; m_idxk[i] = 1'b1;
                    end else if (!hold) begin
                        m_pos[i]++;
                        if (m_pos[i] == n_of(i) + COMP) m_mode[i] = 2;
                    end
                end
                default: begin
                    if (start) begin m_mode[i] = 1; m_pos[i] = 0; end
                    else begin m_mode[i] = 0; m_idxk[i] = 1'b0; end
                end
            endcase
        end
    endtask

    task automatic step(input logic s, input logic h, input logic a, input logic r);
        start = s; hold = h; abort = a; rst_n = r;
        @(negedge clk);
        check_all();
        update_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; hold = 1'b0; abort = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        // Reset held with start high
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        // Nominal run
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(20);
        // Stall of 3 cycles at iter_idx 5
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(5);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(16);
        // Abort at iter_idx 9, then abort together with hold
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(9);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);
        // Ignored start mid-run
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(14);
        // Back-to-back restart in the DONE cycle of the 16-iteration instance
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(16 + COMP);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(20);
        // Randomized traffic including occasional resets
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
        idle(25);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
